// File: rtl/sub_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   Width   : operand width of the dividend, divisor, quotient and remainder
//   state_e : controller state encoding (IDLE=0, CALC=1, DONE=2)
package sub_div_pkg;

  localparam int unsigned Width = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sub_div_ctrl_sub.sv
// 4-bit ripple-borrow subtractor: d = a - b - bin.
// Ports:
//   a, b : minuend and subtrahend
//   bin  : borrow in
//   d    : difference
//   bout : borrow out (high when a < b + bin)
module sub_div_ctrl_sub
  import sub_div_pkg::*;
(
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  input  logic             bin,
  output logic [Width-1:0] d,
  output logic             bout
);

  logic borrow;

  always_comb begin
    d      = '0;
    borrow = bin;
    for (int i = 0; i < Width; i++) begin
      d[i]   = a[i] ^ b[i] ^ borrow;
      borrow = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow);
    end
    bout = borrow;
  end

endmodule

// File: rtl/sub_div_ctrl.sv
// Sequential 4-bit unsigned restoring divider controller.
// Produces one quotient bit per CALC cycle, MSB first, through a single subtractor.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   start : begin a division (sampled in IDLE only)
//   A, B  : dividend and divisor, sampled with start
//   busy  : high whenever not IDLE
//   done  : one-cycle pulse, results valid
//   Q, R  : registered quotient and remainder
//   dz    : registered divide-by-zero flag
module sub_div_ctrl
  import sub_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] Q,
  output logic [Width-1:0] R,
  output logic             dz
);

  state_e state_q, state_d;

  logic [Width-1:0] dvd_q, dvd_d;  // dividend shift register
  logic [Width-1:0] dvs_q, dvs_d;  // divisor
  logic [Width-1:0] rem_q, rem_d;  // partial remainder
  logic [Width-1:0] quo_q, quo_d;  // quotient being assembled
  logic [1:0]       cnt_q, cnt_d;
  logic [Width-1:0] q_q, q_d;
  logic [Width-1:0] r_q, r_d;
  logic             dz_q, dz_d;

  logic [Width-1:0] p;
  logic [Width-1:0] diff;
  logic             bout;
  logic             take;
  logic [Width-1:0] rem_next;

  // The partial remainder never exceeds 7 before a shift, so 4 bits suffice.
  assign p = {rem_q[Width-2:0], dvd_q[Width-1]};

  sub_div_ctrl_sub u_sub (
    .a    (p),
    .b    (dvs_q),
    .bin  (1'b0),
    .d    (diff),
    .bout (bout)
  );

  assign take     = ~bout;
  assign rem_next = take ? diff : p;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (B == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 2'd0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d = A;
          dvs_d = B;
          rem_d = '0;
          quo_d = '0;
          cnt_d = 2'd3;
          if (B == '0) begin
            // Divide-by-zero bypasses CALC; results are loaded immediately.
            q_d  = '1;
            r_d  = A;
            dz_d = 1'b1;
          end else begin
            dz_d = 1'b0;
          end
        end
      end
      StCalc: begin
        rem_d = rem_next;
        quo_d = {quo_q[Width-2:0], take};
        dvd_d = {dvd_q[Width-2:0], 1'b0};
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          q_d = {quo_q[Width-2:0], take};
          r_d = rem_next;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
    Q    = q_q;
    R    = r_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_sub_div_ctrl.sv
module tb_sub_div_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a_in = '0;
  logic [3:0] b_in = '0;
  logic       busy, done, dz;
  logic [3:0] q_out, r_out;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  sub_div_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .busy  (busy),
    .done  (done),
    .Q     (q_out),
    .R     (r_out),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: busy window and done-time scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", {31'b0, busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("Q", {28'b0, q_out}, {28'b0, e.q});
          chk("R", {28'b0, r_out}, {28'b0, e.r});
          chk("dz", {31'b0, dz}, {31'b0, e.dz});
          chk("done_cycle", cyc, e.cyc);
        end
      end else if (done !== 1'b0) begin
        chk("done_x", {31'b0, done}, 0);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Drive one start (called at a negedge while idle); pushes the model result.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int   acc;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    acc  = cyc;
    e.dz = (b == 0);
    e.q  = (b == 0) ? 4'hF : 4'(int'(a) / int'(b));
    e.r  = (b == 0) ? a : 4'(int'(a) % int'(b));
    e.cyc = acc + ((b == 0) ? 0 : 4);
    sb.push_back(e);
    busy_lo = acc;
    busy_hi = e.cyc;
    start = 1'b0;
    a_in  = 4'($urandom);
    b_in  = 4'($urandom);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_Q", {28'b0, q_out}, 0);
    chk("rst_R", {28'b0, r_out}, 0);
    chk("rst_dz", {31'b0, dz}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    wait_idle(); issue(4'd13, 4'd4);
    wait_idle(); issue(4'd15, 4'd1);
    wait_idle(); issue(4'd7, 4'd9);
    wait_idle(); issue(4'd0, 4'd5);
    wait_idle(); issue(4'd15, 4'd0);
    wait_idle(); issue(4'd6, 4'd3);

    // A second start during CALC must be ignored
    wait_idle(); issue(4'd13, 4'd4);
    @(negedge clk);
    start = 1'b1; a_in = 4'd9; b_in = 4'd2;
    @(negedge clk);
    start = 1'b0;

    // Reset in cycle 3 of CALC abandons the operation
    wait_idle(); issue(4'd13, 4'd4);
    @(posedge clk);
    @(posedge clk);
    #2;
    sb.delete();
    busy_lo = 1;
    busy_hi = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    chk("midrst_Q", {28'b0, q_out}, 0);
    chk("midrst_R", {28'b0, r_out}, 0);
    chk("midrst_dz", {31'b0, dz}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        wait_idle();
        issue(4'(a), 4'(b));
      end
    end

    // Random operations with random idle gaps
    for (int n = 0; n < 150; n++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(4'($urandom), 4'($urandom));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
